map_buffer: RTL and testbench

Card-map storage stage that sits directly upstream of the card renderer and drives its packed `map` bus (8 rows × 18 columns × 6-bit card codes). Game logic edits a working copy through a single-command valid/ready port. With shadowing compiled in, the renderer sees a display copy that is refreshed only at a frame boundary after an explicit commit, so a frame never shows a half-applied move.

---
 rtl/map_buffer_if.sv | 21 ++
 rtl/map_buffer.sv | 140 ++++++++++++++
 tb/tb_map_buffer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/map_buffer_if.sv
// Command port of map_buffer: one valid/ready command in, done/err completion pulses out.
interface map_buffer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_dst;
  logic [7:0] cmd_src;
  logic [5:0] cmd_card;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_card,
    input  cmd_ready, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_card,
    output cmd_ready, done, err
  );
endinterface

// File: rtl/map_buffer.sv
// 8x18 card-map store: working copy edited by commands, packed map bus for the renderer.
// Define MAP_BUFFER_SHADOW_EN for a display copy refreshed at frame_start after COMMIT.
module map_buffer (
  input  logic         clk,
  input  logic         rst,
  map_buffer_if.slave  cmd,
  input  logic         frame_start,
  input  logic [7:0]   rd_pos,
  output logic [5:0]   rd_card,
  output logic [863:0] map
);

  localparam int unsigned ENTRIES  = 144;
  localparam logic [7:0]  LAST_IDX = 8'd143;
  localparam logic [1:0]  OP_WRITE  = 2'd0;
  localparam logic [1:0]  OP_MOVE   = 2'd1;
  localparam logic [1:0]  OP_CLEAR  = 2'd2;
  localparam logic [1:0]  OP_COMMIT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_CLEAR,
    S_WAIT_FRAME,
    S_FINISH
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_work [ENTRIES];
  logic [7:0] r_cnt;
  logic [7:0] r_src;
  logic [7:0] r_dst;
  logic [5:0] r_mcard;
  logic       r_ready;
  logic       r_err;
  logic       w_accept;
  logic       w_reject;

  assign w_accept = cmd.cmd_valid && r_ready;
  assign w_reject = ((cmd.cmd_op == OP_WRITE) && (cmd.cmd_dst > LAST_IDX)) ||
                    ((cmd.cmd_op == OP_MOVE) &&
                     ((cmd.cmd_dst > LAST_IDX) || (cmd.cmd_src > LAST_IDX)));

  assign cmd.cmd_ready = r_ready;
  assign cmd.done      = (r_state == S_FINISH);
  assign cmd.err       = (r_state == S_FINISH) && r_err;

  assign rd_card = (rd_pos > LAST_IDX) ? 6'd0 : r_work[rd_pos];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reject) begin
            w_next = S_FINISH;
          end else begin
            case (cmd.cmd_op)
              OP_MOVE:   w_next = S_MOVE;
              OP_CLEAR:  w_next = S_CLEAR;
`ifdef MAP_BUFFER_SHADOW_EN
              OP_COMMIT: w_next = S_WAIT_FRAME;
`else
              OP_COMMIT: w_next = S_FINISH;
`endif
              default:   w_next = S_FINISH;
            endcase
          end
        end
      end
      S_MOVE:       w_next = S_FINISH;
      S_CLEAR:      if (r_cnt == LAST_IDX) w_next = S_FINISH;
      S_WAIT_FRAME: if (frame_start) w_next = S_FINISH;
      S_FINISH:     w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Control state and working storage (storage must clear on reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < ENTRIES; i++) r_work[i] <= '0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_IDLE);
      if (w_accept) begin
        r_err <= w_reject;
        r_cnt <= '0;
        if (!w_reject && (cmd.cmd_op == OP_WRITE)) r_work[cmd.cmd_dst] <= cmd.cmd_card;
      end
      case (r_state)
        // src is cleared first so that src==dst leaves the card in place
        S_MOVE: begin
          if (r_src != r_dst) r_work[r_src] <= '0;
          r_work[r_dst] <= r_mcard;
        end
        S_CLEAR: begin
          r_work[r_cnt] <= '0;
          r_cnt         <= r_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Accept-time latch of MOVE operands
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_src   <= cmd.cmd_src;
      r_dst   <= cmd.cmd_dst;
      r_mcard <= (cmd.cmd_src > LAST_IDX) ? 6'd0 : r_work[cmd.cmd_src];
    end
  end

`ifdef MAP_BUFFER_SHADOW_EN
  logic [5:0] r_disp [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_disp[i] <= '0;
    end else if ((r_state == S_WAIT_FRAME) && frame_start) begin
      for (int i = 0; i < ENTRIES; i++) r_disp[i] <= r_work[i];
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_map
    assign map[g*6 +: 6] = r_disp[g];
  end
`else
  for (genvar g = 0; g < ENTRIES; g++) begin : g_map
    assign map[g*6 +: 6] = r_work[g];
  end
`endif

endmodule

// File: tb/tb_map_buffer.sv
// Scoreboard bench for map_buffer: reference map model, expected completions queued at issue.
module tb_map_buffer;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         frame_start = 1'b0;
  logic [7:0]   rd_pos = 8'd0;
  logic [5:0]   rd_card;
  logic [863:0] map;

  map_buffer_if ifc ();

  map_buffer dut (
    .clk(clk),
    .rst(rst),
    .cmd(ifc.slave),
    .frame_start(frame_start),
    .rd_pos(rd_pos),
    .rd_card(rd_card),
    .map(map)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic err;
    int   cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         m_work[144];
  int         m_disp[144];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [5:0] rd_pre;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: every completion pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (ifc.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'd0, ifc.done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_err", {31'd0, ifc.err}, {31'd0, e.err});
      end
    end else if (ifc.err === 1'b1) begin
      chk("err_without_done", {31'd0, ifc.err}, 32'd0);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 144; i++) begin
      m_work[i] = 0;
      m_disp[i] = 0;
    end
  endtask

  task automatic chk_map(input string nm);
    int mm;
    int first;
    int ev;
    mm = 0;
    first = -1;
    for (int i = 0; i < 144; i++) begin
`ifdef MAP_BUFFER_SHADOW_EN
      ev = m_disp[i];
`else
      ev = m_work[i];
`endif
      if (map[i*6 +: 6] !== 6'(ev)) begin
        mm++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_bad_entries_first%0d", nm, first), mm, 0);
  endtask

  task automatic sweep(input string nm);
    int mm;
    int first;
    mm = 0;
    first = -1;
    for (int i = 0; i < 144; i++) begin
      rd_pos = 8'(i);
      #1;
      if (rd_card !== 6'(m_work[i])) begin
        mm++;
        if (first < 0) first = i;
      end
    end
    chk($sformatf("%s_bad_entries_first%0d", nm, first), mm, 0);
    rd_pos = 8'd200;
    #1;
    chk({nm, "_rd_out_of_range"}, {26'd0, rd_card}, 32'd0);
  endtask

  task automatic send(input int op, input int dst, input int src, input int card,
                      input bit fs, input bit push, output int n);
    int k;
    bit e;
    int lat;
    int c;
    k = 0;
    @(negedge clk);
    while (ifc.cmd_ready !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_send", {31'd0, ifc.cmd_ready}, 32'd1);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_op    = 2'(op);
    ifc.cmd_dst   = 8'(dst);
    ifc.cmd_src   = 8'(src);
    ifc.cmd_card  = 6'(card);
    frame_start   = fs;
    n = cyc;
    #1 rd_pre = rd_card;
    e = 1'b0;
    lat = 1;
    case (op)
      0: if (dst < 144) m_work[dst] = card; else e = 1'b1;
      1: begin
        if (dst < 144 && src < 144) begin
          c = m_work[src];
          m_work[src] = 0;
          m_work[dst] = c;
          lat = 2;
        end else begin
          e = 1'b1;
        end
      end
      2: begin
        for (int i = 0; i < 144; i++) m_work[i] = 0;
        lat = 145;
      end
      default: begin
`ifdef MAP_BUFFER_SHADOW_EN
        push = 1'b0;
`endif
      end
    endcase
    if (push) exp_q.push_back('{e, n + lat});
    @(posedge clk);
    #1;
    ifc.cmd_valid = 1'b0;
    frame_start   = 1'b0;
    ifc.cmd_op    = 2'($urandom);
    ifc.cmd_dst   = 8'($urandom);
    ifc.cmd_src   = 8'($urandom);
    ifc.cmd_card  = 6'($urandom);
  endtask

  task automatic commit(input int delay, input bit fs_acc);
    int n;
    send(3, 0, 0, 0, fs_acc, 1'b1, n);
`ifdef MAP_BUFFER_SHADOW_EN
    repeat (delay) @(negedge clk);
    chk_map("map_before_frame");
    chk("ready_in_wait_frame", {31'd0, ifc.cmd_ready}, 32'd0);
    frame_start = 1'b1;
    exp_q.push_back('{1'b0, cyc + 1});
    m_disp = m_work;
    @(negedge clk);
    frame_start = 1'b0;
    chk_map("map_after_frame");
`else
    if (delay < 0) $display("unused delay");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int op;
    int d;
    int s;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_op    = 2'd0;
    ifc.cmd_dst   = 8'd0;
    ifc.cmd_src   = 8'd0;
    ifc.cmd_card  = 6'd0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ifc.cmd_ready}, 32'd0);
    chk("reset_done", {31'd0, ifc.done}, 32'd0);
    chk("reset_err", {31'd0, ifc.err}, 32'd0);
    chk_map("reset_map");
    rst = 1'b0;
    chk("ready_release_cycle", {31'd0, ifc.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_release", {31'd0, ifc.cmd_ready}, 32'd1);

    // WRITE then delayed COMMIT
    rd_pos = 8'd5;
    send(0, 5, 0, 'h2A, 1'b0, 1'b1, n);
    chk("rd_old_data_in_write_cycle", {26'd0, rd_pre}, 32'd0);
    chk("rd_card5_after_write", {26'd0, rd_card}, 32'h2A);
    chk_map("map_after_write5");
    commit(10, 1'b0);

    // Corner entry and MOVE
    send(0, 143, 0, 'h3F, 1'b0, 1'b1, n);
    send(1, 0, 143, 0, 1'b0, 1'b1, n);
    commit(3, 1'b0);
    chk("map_entry0", {26'd0, map[5:0]}, 32'h3F);
    chk("map_entry143", {26'd0, map[863:858]}, 32'h0);

    // Rejected commands
    send(0, 144, 0, 'h15, 1'b0, 1'b1, n);
    send(1, 3, 200, 0, 1'b0, 1'b1, n);
    send(1, 150, 0, 0, 1'b0, 1'b1, n);
    sweep("work_after_reject");

    // Direct map visibility check of a plain WRITE
    send(0, 7, 0, 'h11, 1'b0, 1'b1, n);
    chk_map("map_after_write7");

    // Randomized edits
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 1 : 0;
      d  = $urandom_range(0, 159);
      s  = ($urandom_range(0, 7) == 0) ? d : $urandom_range(0, 159);
      send(op, d, s, $urandom_range(1, 63), 1'b0, 1'b1, n);
    end
    sweep("work_after_random");
    chk_map("map_after_random");
`ifdef MAP_BUFFER_SHADOW_EN
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk_map("map_idle_frame_ignored");
`endif
    commit(2, 1'b0);

    // CLEAR
    send(2, 0, 0, 0, 1'b0, 1'b1, n);
    cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (ifc.cmd_ready === 1'b1) break;
      cnt++;
    end
    chk("clear_ready_low_cycles", cnt, 145);
    sweep("work_after_clear");
    chk_map("map_after_clear");

    // COMMIT with frame_start in the accept cycle
    commit(4, 1'b1);

    // Reset aborting an in-flight command
    send(0, 10, 0, 'h3, 1'b0, 1'b1, n);
    commit(2, 1'b0);
`ifdef MAP_BUFFER_SHADOW_EN
    send(3, 0, 0, 0, 1'b0, 1'b0, n);
`else
    send(2, 0, 0, 0, 1'b0, 1'b0, n);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    chk_map("map_in_reset");
    chk("ready_in_reset", {31'd0, ifc.cmd_ready}, 32'd0);
    chk("done_in_reset", {31'd0, ifc.done}, 32'd0);
    rst = 1'b0;
    chk("ready_abort_release_cycle", {31'd0, ifc.cmd_ready}, 32'd0);
    @(negedge clk);
    chk("ready_abort_after_release", {31'd0, ifc.cmd_ready}, 32'd1);
    sweep("work_after_abort");

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
